// File: rtl/pic_pkg.sv
// pic_pkg: shared FSM states, OCW2 command codes and priority helpers for the PIC acknowledge logic.
package pic_pkg;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACK1, S_WAIT2, S_ACK2} state_t;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_S_EOI        = 3'b011;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_ROT_S_EOI    = 3'b111;
  localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  function automatic logic [2:0] rank(input logic [2:0] level, input logic [2:0] rotate);
    return level - rotate - 3'd1;
  endfunction
  function automatic logic [2:0] onehot_index(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) if (oh[i]) idx = 3'(i);
    return idx;
  endfunction
endpackage

// File: rtl/priority_resolver.sv
// priority_resolver: picks the best-ranked pending request and qualifies it against the in-service level.
module priority_resolver
  import pic_pkg::*;
(
  input  logic [7:0] request,
  input  logic [2:0] rotate,
  input  logic [7:0] in_service,
  output logic       valid,
  output logic [7:0] onehot,
  output logic [2:0] index
);
  logic       found;
  logic [2:0] lvl;
  always_comb begin
    found = 1'b0;
    index = 3'd0;
    lvl   = 3'd0;
    for (int r = 7; r >= 0; r--) begin
      lvl = rotate + 3'(r) + 3'd1;
      if (request[lvl]) begin
        found = 1'b1;
        index = lvl;
      end
    end
    valid  = found && (in_service == 8'd0 ||
             rank(index, rotate) < rank(onehot_index(in_service), rotate));
    onehot = valid ? 8'd1 << index : 8'd0;
  end
endmodule

// File: rtl/interrupt_ack_control.sv
// interrupt_ack_control: INT/INTA sequencer and OCW2 EOI/rotate decoder feeding the ISR.
// Automatic EOI and AEOI rotation exist only when PIC_AUTO_EOI_EN is defined.
module interrupt_ack_control
  import pic_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inta_n,
  input  logic [7:0] interrupt_request,
  input  logic [7:0] in_service_register,
  input  logic [7:0] highest_level_in_service,
  input  logic [2:0] priority_rotate,
  input  logic [4:0] icw2_vector,
  input  logic       aeoi_mode,
  input  logic       ocw2_write,
  input  logic [7:0] ocw2_data,
  output logic       int_out,
  output logic       latch_in_service,
  output logic [7:0] interrupt,
  output logic [7:0] end_of_interrupt,
  output logic       priority_rotate_load,
  output logic [2:0] priority_rotate_next,
  output logic [7:0] vector_out,
  output logic       vector_drive,
  output logic       ack_abort
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  state_t     state_q, state_d;
  logic       inta_q, fall, cand_valid, ns, sp;
  logic [7:0] cand_onehot;
  logic [2:0] cand_idx, cmd, lvl, level_q, level_d, rot_next_q, rot_next_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic       spur_q, spur_d, int_q, int_d, latch_q, latch_d, load_q, load_d;
  logic       vdrv_q, vdrv_d, abort_q, abort_d;
  logic [7:0] irq_q, irq_d, eoi_q, eoi_d, vec_q, vec_d;
  logic       unused_ok;
`ifdef PIC_AUTO_EOI_EN
  logic       flag_q, flag_d;
  assign unused_ok = ^{in_service_register, ocw2_data[4:3]};
`else
  assign unused_ok = ^{in_service_register, ocw2_data[4:3], aeoi_mode};
`endif
  priority_resolver u_res (
    .request   (interrupt_request),
    .rotate    (priority_rotate),
    .in_service(highest_level_in_service),
    .valid     (cand_valid),
    .onehot    (cand_onehot),
    .index     (cand_idx)
  );
  always_comb begin
    fall       = inta_q & ~inta_n;
    cmd        = ocw2_data[7:5];
    lvl        = ocw2_data[2:0];
    state_d    = state_q;
    cnt_d      = '0;
    level_d    = level_q;
    spur_d     = spur_q;
    latch_d    = 1'b0;
    irq_d      = 8'd0;
    abort_d    = 1'b0;
    eoi_d      = 8'd0;
    load_d     = 1'b0;
    rot_next_d = rot_next_q;
`ifdef PIC_AUTO_EOI_EN
    flag_d     = flag_q;
`endif
    case (state_q)
      S_IDLE:
        if (fall) begin
          level_d = 3'd7;
          spur_d  = 1'b1;
          state_d = S_ACK1;
        end else if (cand_valid) state_d = S_REQ;
      S_REQ:
        if (fall) begin
          level_d = cand_valid ? cand_idx : 3'd7;
          spur_d  = ~cand_valid;
          latch_d = cand_valid;
          irq_d   = cand_onehot;
          state_d = S_ACK1;
        end else if (!cand_valid) state_d = S_IDLE;
      S_ACK1: state_d = S_WAIT2;
      S_WAIT2:
        if (fall) state_d = S_ACK2;
        else if (cnt_q == CW'(ACK_TIMEOUT)) begin
          abort_d = 1'b1;
          eoi_d   = spur_q ? 8'd0 : 8'd1 << level_q;
          state_d = S_IDLE;
        end else cnt_d = cnt_q + 1'b1;
      S_ACK2:
        if (inta_n) begin
          state_d = S_IDLE;
`ifdef PIC_AUTO_EOI_EN
          if (aeoi_mode && !spur_q) begin
            eoi_d = 8'd1 << level_q;
            if (flag_q) begin
              load_d     = 1'b1;
              rot_next_d = level_q;
            end
          end
`endif
        end
      default: state_d = S_IDLE;
    endcase
    // OCW2 is applied after AEOI so its rotate value takes precedence
    ns = ocw2_write && (cmd == OCW2_NS_EOI || cmd == OCW2_ROT_NS_EOI);
    sp = ocw2_write && (cmd == OCW2_S_EOI || cmd == OCW2_ROT_S_EOI);
    eoi_d = eoi_d | (ns ? highest_level_in_service : sp ? 8'd1 << lvl : 8'd0);
    if (ocw2_write && cmd == OCW2_ROT_NS_EOI && highest_level_in_service != 8'd0) begin
      load_d     = 1'b1;
      rot_next_d = onehot_index(highest_level_in_service);
    end
    if (ocw2_write && (cmd == OCW2_ROT_S_EOI || cmd == OCW2_SET_PRI)) begin
      load_d     = 1'b1;
      rot_next_d = lvl;
    end
`ifdef PIC_AUTO_EOI_EN
    if (ocw2_write && cmd == OCW2_ROT_AEOI_SET) flag_d = 1'b1;
    if (ocw2_write && cmd == OCW2_ROT_AEOI_CLR) flag_d = 1'b0;
`endif
    int_d  = state_d == S_REQ;
    vdrv_d = state_d == S_ACK2;
    vec_d  = vdrv_d ? {icw2_vector, level_d} : 8'd0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      inta_q     <= 1'b1;
      cnt_q      <= '0;
      level_q    <= 3'd0;
      spur_q     <= 1'b0;
      int_q      <= 1'b0;
      latch_q    <= 1'b0;
      irq_q      <= 8'd0;
      eoi_q      <= 8'd0;
      load_q     <= 1'b0;
      rot_next_q <= 3'd0;
      vec_q      <= 8'd0;
      vdrv_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      inta_q     <= inta_n;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      spur_q     <= spur_d;
      int_q      <= int_d;
      latch_q    <= latch_d;
      irq_q      <= irq_d;
      eoi_q      <= eoi_d;
      load_q     <= load_d;
      rot_next_q <= rot_next_d;
      vec_q      <= vec_d;
      vdrv_q     <= vdrv_d;
      abort_q    <= abort_d;
    end
  end
`ifdef PIC_AUTO_EOI_EN
  always_ff @(posedge clock) flag_q <= reset ? 1'b0 : flag_d;
`endif
  assign int_out              = int_q;
  assign latch_in_service     = latch_q;
  assign interrupt            = irq_q;
  assign end_of_interrupt     = eoi_q;
  assign priority_rotate_load = load_q;
  assign priority_rotate_next = rot_next_q;
  assign vector_out           = vec_q;
  assign vector_drive         = vdrv_q;
  assign ack_abort            = abort_q;
endmodule

// File: tb/tb_interrupt_ack_control.sv
// tb_interrupt_ack_control: directed checks of INT/INTA sequencing, OCW2 decode and timeout abort.
module tb_interrupt_ack_control;
  logic       clock = 1'b0, reset, inta_n, aeoi_mode, ocw2_write;
  logic [7:0] interrupt_request, in_service_register, highest_level_in_service, ocw2_data;
  logic [2:0] priority_rotate;
  logic [4:0] icw2_vector;
  logic       int_out, latch_in_service, priority_rotate_load, vector_drive, ack_abort;
  logic [7:0] interrupt, end_of_interrupt, vector_out;
  logic [2:0] priority_rotate_next;
  int         total = 0, passed = 0;
  always #5 clock = ~clock;
  interrupt_ack_control dut (
    .clock(clock), .reset(reset), .inta_n(inta_n),
    .interrupt_request(interrupt_request), .in_service_register(in_service_register),
    .highest_level_in_service(highest_level_in_service), .priority_rotate(priority_rotate),
    .icw2_vector(icw2_vector), .aeoi_mode(aeoi_mode), .ocw2_write(ocw2_write),
    .ocw2_data(ocw2_data), .int_out(int_out), .latch_in_service(latch_in_service),
    .interrupt(interrupt), .end_of_interrupt(end_of_interrupt),
    .priority_rotate_load(priority_rotate_load), .priority_rotate_next(priority_rotate_next),
    .vector_out(vector_out), .vector_drive(vector_drive), .ack_abort(ack_abort)
  );
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic ocw2(input logic [7:0] d);
    ocw2_write = 1'b1;
    ocw2_data  = d;
    tick();
    ocw2_write = 1'b0;
  endtask
  task automatic full_ack(input string t, input logic [7:0] irq, input logic [7:0] vec);
    inta_n = 1'b0;
    tick();
    chk({t, "_latch"}, latch_in_service, irq != 8'd0);
    chk({t, "_irq"}, interrupt, irq);
    chk({t, "_int_drop"}, int_out, 0);
    interrupt_request = 8'd0;
    tick();
    chk({t, "_latch_1cyc"}, latch_in_service, 0);
    inta_n = 1'b1;
    tick();
    tick();
    inta_n = 1'b0;
    tick();
    chk({t, "_vdrv"}, vector_drive, 1);
    chk({t, "_vec"}, vector_out, vec);
    inta_n = 1'b1;
    tick();
    chk({t, "_vdrv_off"}, vector_drive, 0);
  endtask
  initial begin
    int n;
    reset = 1'b1; inta_n = 1'b1; aeoi_mode = 1'b0; ocw2_write = 1'b0; ocw2_data = 8'd0;
    interrupt_request = 8'd0; in_service_register = 8'd0; highest_level_in_service = 8'd0;
    priority_rotate = 3'd7; icw2_vector = 5'h08;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_int", int_out, 0);
    chk("rst_latch", latch_in_service, 0);
    chk("rst_vdrv", vector_drive, 0);
    chk("rst_eoi", end_of_interrupt, 0);
    chk("rst_load", priority_rotate_load, 0);
    interrupt_request = 8'h24;
    tick();
    chk("t1_int_rise", int_out, 1);
    full_ack("t1", 8'h04, 8'h42);
    chk("t1_no_eoi", end_of_interrupt, 0);
    highest_level_in_service = 8'h02;
    interrupt_request = 8'h08;
    tick();
    tick();
    chk("nest_blocked", int_out, 0);
    interrupt_request = 8'h01;
    tick();
    chk("nest_higher", int_out, 1);
    interrupt_request = 8'h00;
    tick();
    chk("req_vanish", int_out, 0);
    highest_level_in_service = 8'h10;
    ocw2(8'hA0);
    chk("rot_ns_eoi", end_of_interrupt, 8'h10);
    chk("rot_ns_load", priority_rotate_load, 1);
    chk("rot_ns_next", priority_rotate_next, 4);
    tick();
    chk("eoi_1cyc", end_of_interrupt, 0);
    chk("load_1cyc", priority_rotate_load, 0);
    ocw2(8'h63);
    chk("s_eoi", end_of_interrupt, 8'h08);
    chk("s_eoi_noload", priority_rotate_load, 0);
    ocw2(8'hC5);
    chk("setpri_noeoi", end_of_interrupt, 0);
    chk("setpri_next", priority_rotate_next, 5);
    ocw2(8'hE6);
    chk("rot_s_eoi", end_of_interrupt, 8'h40);
    chk("rot_s_next", priority_rotate_next, 6);
    highest_level_in_service = 8'h00;
    ocw2(8'hA0);
    chk("ns_empty_eoi", end_of_interrupt, 0);
    chk("ns_empty_load", priority_rotate_load, 0);
    interrupt_request = 8'h10;
    tick();
    chk("to_int", int_out, 1);
    inta_n = 1'b0;
    tick();
    chk("to_irq", interrupt, 8'h10);
    interrupt_request = 8'h00;
    inta_n = 1'b1;
    n = 0;
    while (!ack_abort && n < 400) begin
      tick();
      n++;
    end
    chk("to_abort_seen", ack_abort, 1);
    chk("to_abort_delay", n >= 255 && n < 400, 1);
    chk("to_abort_eoi", end_of_interrupt, 8'h10);
    tick();
    chk("to_abort_1cyc", ack_abort, 0);
    chk("to_idle_int", int_out, 0);
`ifdef PIC_AUTO_EOI_EN
    aeoi_mode = 1'b1;
    ocw2(8'h80);
    chk("aeoi_flag_noeoi", end_of_interrupt, 0);
    interrupt_request = 8'h08;
    tick();
    chk("aeoi_int", int_out, 1);
    full_ack("aeoi", 8'h08, 8'h43);
    chk("aeoi_eoi", end_of_interrupt, 8'h08);
    chk("aeoi_load", priority_rotate_load, 1);
    chk("aeoi_next", priority_rotate_next, 3);
    tick();
    chk("aeoi_eoi_1cyc", end_of_interrupt, 0);
`endif
    aeoi_mode = 1'b1;
    full_ack("spur", 8'h00, 8'h47);
    chk("spur_no_eoi", end_of_interrupt, 0);
    chk("spur_no_load", priority_rotate_load, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/interrupt_ack_control.md
# interrupt_ack_control

Acknowledge and end-of-interrupt sequencer for the 8259-compatible PIC. It resolves the highest-priority pending request against the in-service register and raises INT. It runs the two-pulse 8086 INTA cycle and drives `latch_in_service`/`interrupt` into the in-service register. It decodes OCW2 into `end_of_interrupt` masks and priority-rotation updates, acting as the producer end of the in-service register's set/clear interface.

## Interface
- `ACK_TIMEOUT`, default 255: maximum cycles between first and second INTA pulse before the cycle is aborted; counter width is `$clog2(ACK_TIMEOUT+1)`.
- `clock` in 1: sole clock; everything is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `inta_n` in 1: CPU acknowledge strobe, active-low, already synchronized to `clock`.
- `interrupt_request` in 8: pending requests, already masked (IRR & ~IMR).
- `in_service_register` in 8: current ISR contents.
- `highest_level_in_service` in 8: one-hot highest in-service level, 0 if none.
- `priority_rotate` in 3: current lowest-priority level.
- `icw2_vector` in 5: vector bits T7..T3.
- `aeoi_mode` in 1: automatic EOI enable; ignored unless `PIC_AUTO_EOI_EN`.
- `ocw2_write` in 1: one-cycle strobe qualifying `ocw2_data`.
- `ocw2_data` in 8: R, SL, EOI in bits 7:5; L2..L0 in bits 2:0.
- `int_out` out 1: INT request to the CPU.
- `latch_in_service` out 1: one-cycle set strobe to the ISR.
- `interrupt` out 8: one-hot level being acknowledged, valid with `latch_in_service`.
- `end_of_interrupt` out 8: one-cycle ISR clear mask.
- `priority_rotate_load` out 1, `priority_rotate_next` out 3: one-cycle update of the rotation register.
- `vector_out` out 8, `vector_drive` out 1: data-bus vector and its enable.
- `ack_abort` out 1: one-cycle pulse on timeout.

## Operation
- Priority rank of level i is (i − priority_rotate − 1) mod 8; the lowest rank wins.
- Candidate: best-ranked bit of `interrupt_request`. It qualifies only if its rank is strictly lower than the rank of `highest_level_in_service` (fully nested mode), or if none is in service.
- States:
  - IDLE: enter REQ when a qualified candidate exists.
  - REQ: `int_out`=1. If the candidate vanishes before the first INTA falling edge, return to IDLE.
  - ACK1: on the first INTA falling edge, freeze the candidate as `level`, pulse `latch_in_service` with `interrupt`=1<<level, drop `int_out`.
  - WAIT2: count cycles until the next INTA falling edge, then go to ACK2. At count==ACK_TIMEOUT: pulse `ack_abort` and `end_of_interrupt`=1<<level (undo the latch), go to IDLE.
  - ACK2: `vector_drive`=1, `vector_out`={icw2_vector, level} while `inta_n` is low. On the INTA rising edge go to IDLE, issuing AEOI if enabled.
- Spurious INTA:
  - First falling edge in IDLE: treat as level 7 with no `latch_in_service`.
  - In REQ after the request dropped: same, level 7 with no `latch_in_service`.
  - The vector still returns {icw2_vector, 3'd7}.
- OCW2 decode, registered one cycle after `ocw2_write`:
  - 001 non-specific EOI: clear `highest_level_in_service`.
  - 011 specific EOI: clear 1<<L.
  - 101 rotate on non-specific EOI: clear the highest level; rotate_next = its index.
  - 111 rotate on specific EOI: clear 1<<L; rotate_next = L.
  - 110 set priority: rotate_next = L, no clear.
  - 010 no-op. 000/100: see Configuration.
- Non-specific EOI with `highest_level_in_service`==0: `end_of_interrupt`=0, no rotate load.
- An OCW2 clear in the same cycle as an AEOI or abort clear: both masks are ORed into one pulse.
- If both an OCW2 and an AEOI rotate load in the same cycle, the OCW2 value wins.

## Timing
- `inta_n` is registered internally. An edge is detected in cycle n; the resulting registered outputs change in cycle n+1.
- `int_out` rises the cycle after a qualified candidate appears.
- `latch_in_service` and `interrupt` are valid only in cycle n+1 after the first falling edge.
- `vector_drive` rises at n+1 after the second falling edge and falls the cycle after `inta_n` is sampled high.
- `end_of_interrupt`, `priority_rotate_load` and `ack_abort` are exactly one cycle wide.
- Reset: state IDLE; every output 0; counter 0; AEOI-rotate flag 0. A reset mid-acknowledge issues no EOI.

## Configuration
- `PIC_AUTO_EOI_EN` defined:
  - With `aeoi_mode`=1, the second INTA rising edge pulses `end_of_interrupt`=1<<level. Spurious level 7 gets no pulse.
  - OCW2 100 sets and 000 clears an AEOI-rotate flag. With the flag set, the same AEOI also loads rotate_next=level.
- Undefined: `aeoi_mode` is ignored, OCW2 000/100 are no-ops, and there is no flag register.

## Structure
- `pic_pkg`: state enum, OCW2 command encodings (`OCW2_NS_EOI`, `OCW2_S_EOI`, `OCW2_ROT_NS_EOI`, `OCW2_ROT_S_EOI`, `OCW2_SET_PRI`, `OCW2_ROT_AEOI_SET`, `OCW2_ROT_AEOI_CLR`), and the rank function.
- Sub-module `priority_resolver`: combinational. Takes requests, rotate and in-service, and returns candidate valid, one-hot and index.

## Test plan
- rotate=7, request=8'h24, ISR=0, icw2_vector=5'h08: `int_out` rises; INTA#1 -> `interrupt`=8'h04 latched; INTA#2 -> `vector_out`=8'h42.
- ISR highest=8'h02, request=8'h08, rotate=7 -> `int_out` stays 0. Request changed to 8'h01 -> `int_out`=1.
- OCW2=8'hA0 with highest in service=8'h10 -> `end_of_interrupt`=8'h10, `priority_rotate_next`=4, load=1.
- INTA#1 then no second pulse for 255 cycles -> `ack_abort`=1 and `end_of_interrupt`=1<<level in the same cycle; state IDLE.
- `PIC_AUTO_EOI_EN`, `aeoi_mode`=1, level 3 -> `end_of_interrupt`=8'h08 the cycle after the INTA#2 rising edge. Spurious INTA -> vector {icw2_vector,3'd7}, no latch, no EOI.
